// File: rtl/target_sync_controller_if.sv
// Purpose : memory-side bundle between the sync controller and the policy/target net memories.
// Latency : none (wires only); source read data is expected one cycle after the read strobe.
// Backpressure: none; both memories must accept a strobe in the cycle it is asserted.
// Ports   : master = controller side (drives strobes/addresses, receives source row);
//           slave  = memory side (receives strobes/addresses, returns source row).
interface target_sync_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WIDTH  = 5,
    parameter int WEIGHT_W   = DATA_WIDTH * 32
);
    // policy-net (source) read port
    logic                  o_src_mem_enable;
    logic                  o_src_rw_mem;
    logic [1:0]            o_src_layer;
    logic [MEM_WIDTH-1:0]  o_src_addr;
    logic [WEIGHT_W-1:0]   i_src_weight;
    logic [DATA_WIDTH-1:0] i_src_bias;

    // target-net (destination) write port
    logic                  o_dst_mem_enable;
    logic                  o_dst_rw_mem;
    logic                  o_dst_update_weight;
    logic [1:0]            o_dst_layer;
    logic [MEM_WIDTH-1:0]  o_dst_addr;
    logic [WEIGHT_W-1:0]   o_dst_weight;
    logic [DATA_WIDTH-1:0] o_dst_bias;

    modport master (
        output o_src_mem_enable, o_src_rw_mem, o_src_layer, o_src_addr,
        input  i_src_weight, i_src_bias,
        output o_dst_mem_enable, o_dst_rw_mem, o_dst_update_weight,
        output o_dst_layer, o_dst_addr, o_dst_weight, o_dst_bias
    );

    modport slave (
        input  o_src_mem_enable, o_src_rw_mem, o_src_layer, o_src_addr,
        output i_src_weight, i_src_bias,
        input  o_dst_mem_enable, o_dst_rw_mem, o_dst_update_weight,
        input  o_dst_layer, o_dst_addr, o_dst_weight, o_dst_bias
    );
endinterface

// File: rtl/target_sync_controller.sv
// Purpose : copies every weight row/bias of the policy net into the target net, node by node.
// Latency : 2*(H1+H2+OUT)+1 cycles from first READ through the o_sync_done pulse.
// Backpressure: none; a trigger arriving while busy is dropped (force) or held pending (period).
// Ports   : clk/rst (sync, active high); i_step training-step pulse; i_force_sync immediate
//           request; bus = source read / target write memory ports; o_busy, o_sync_done,
//           o_sync_count status.
module target_sync_controller #(
    parameter int DATA_WIDTH          = 32,
    parameter int MEM_WIDTH           = 5,
    parameter int NODE_WIDTH_HIDDEN_1 = 32,
    parameter int NODE_WIDTH_HIDDEN_2 = 32,
    parameter int NODE_WIDTH_OUTPUT   = 3,
    parameter int MAX_FAN_IN          = 32,
    parameter int SYNC_PERIOD         = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_step,
    input  logic        i_force_sync,
    target_sync_if.master bus,
    output logic        o_busy,
    output logic        o_sync_done,
    output logic [15:0] o_sync_count
);
    localparam int          WEIGHT_W  = DATA_WIDTH * MAX_FAN_IN;
    localparam logic        STEP_EN   = (SYNC_PERIOD != 0);
    localparam logic [15:0] PERIOD_M1 = STEP_EN ? 16'(SYNC_PERIOD - 1) : 16'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_layer;
    logic [MEM_WIDTH-1:0]  r_addr;
    logic [15:0]           r_step_cnt;
    logic                  r_pending;
    logic [15:0]           r_sync_count;

    logic                  w_period_hit;
    logic                  w_trigger;
    logic                  w_accept;
    logic                  w_layer_end;
    logic                  w_last_node;
    logic                  w_src_en;
    logic                  w_dst_en;
    logic                  w_done;
    logic [WEIGHT_W-1:0]   w_dst_weight;
    logic [DATA_WIDTH-1:0] w_dst_bias;

    function automatic logic [MEM_WIDTH-1:0] last_addr(input logic [1:0] layer);
        case (layer)
            2'd1:    return MEM_WIDTH'(NODE_WIDTH_HIDDEN_1 - 1);
            2'd2:    return MEM_WIDTH'(NODE_WIDTH_HIDDEN_2 - 1);
            default: return MEM_WIDTH'(NODE_WIDTH_OUTPUT - 1);
        endcase
    endfunction

    // The step that reaches the period counts as a trigger in its own cycle, so an idle
    // controller starts reading on the very next cycle instead of waiting a cycle for the flag.
    assign w_period_hit = STEP_EN && i_step && (r_step_cnt == PERIOD_M1);
    assign w_trigger    = r_pending || i_force_sync || w_period_hit;
    assign w_accept     = (r_state == S_IDLE) && w_trigger;
    assign w_layer_end  = (r_addr >= last_addr(r_layer));
    assign w_last_node  = w_layer_end && (r_layer == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_src_en     = 1'b0;
        w_dst_en     = 1'b0;
        w_done       = 1'b0;
        w_dst_weight = '0;
        w_dst_bias   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    w_next = S_READ;
                end
            end
            S_READ: begin
                w_src_en = 1'b1;
                w_next   = S_WRITE;
            end
            S_WRITE: begin
                // source row returned for the previous cycle's read goes straight through
                w_dst_en     = 1'b1;
                w_dst_weight = bus.i_src_weight;
                w_dst_bias   = bus.i_src_bias;
                w_next       = w_last_node ? S_DONE : S_READ;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_layer      <= 2'd0;
            r_addr       <= '0;
            r_step_cnt   <= 16'd0;
            r_pending    <= 1'b0;
            r_sync_count <= 16'd0;
        end else begin
            // steps keep counting while a sync runs; a hit then waits in r_pending
            if (STEP_EN && i_step) begin
                r_step_cnt <= w_period_hit ? 16'd0 : r_step_cnt + 16'd1;
            end
            r_pending <= (r_pending || w_period_hit) && !w_accept;

            if (w_accept) begin
                r_layer <= 2'd1;
                r_addr  <= '0;
            end else if (r_state == S_WRITE && !w_last_node) begin
                if (w_layer_end) begin
                    r_layer <= r_layer + 2'd1;
                    r_addr  <= '0;
                end else begin
                    r_addr <= r_addr + 1'b1;
                end
            end

            if (r_state == S_DONE) begin
                r_sync_count <= r_sync_count + 16'd1;
            end
        end
    end

    // layer/addr are stable across a READ/WRITE pair, so both ports share them
    assign bus.o_src_mem_enable    = w_src_en;
    assign bus.o_src_rw_mem        = 1'b1;
    assign bus.o_src_layer         = r_layer;
    assign bus.o_src_addr          = r_addr;
    assign bus.o_dst_mem_enable    = w_dst_en;
    assign bus.o_dst_rw_mem        = 1'b0;
    assign bus.o_dst_update_weight = 1'b1;
    assign bus.o_dst_layer         = r_layer;
    assign bus.o_dst_addr          = r_addr;
    assign bus.o_dst_weight        = w_dst_weight;
    assign bus.o_dst_bias          = w_dst_bias;

    assign o_busy       = (r_state != S_IDLE);
    assign o_sync_done  = w_done;
    assign o_sync_count = r_sync_count;
endmodule
